// File: rtl/ej32_mb8_arb.sv
// ============================================================================
// ej32_mb8_arb : fetch/data arbiter and big-endian byte sequencer for mb8
// Optional build macro: EJ32_MB8_ARB_RR_EN (round-robin tie-break)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ej32_mb8_arb #(
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           f_req,
    input  logic [ASZ-1:0] f_ai,
    output logic           f_ack,
    output logic [7:0]     f_vo,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [1:0]     d_len,
    input  logic [ASZ-1:0] d_ai,
    input  logic [31:0]    d_vi,
    output logic           d_ack,
    output logic [31:0]    d_vo,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_ai,
    output logic [7:0]     mem_vi,
    input  logic [7:0]     mem_vo,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDL  = 3'd2,
        S_WR   = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           isd_q, isd_d;
    logic [1:0]     last_q, last_d;
    logic [1:0]     k_q, k_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    wdat_q, wdat_d;
    logic [7:0]     f_vo_q, f_vo_d;
    logic [31:0]    d_vo_q, d_vo_d;
    logic           f_ack_q, f_ack_d;
    logic           d_ack_q, d_ack_d;
    logic           mem_we_q, mem_we_d;
    logic [ASZ-1:0] mem_ai_q, mem_ai_d;
    logic [7:0]     mem_vi_q, mem_vi_d;
    logic           busy_q, busy_d;

    logic           data_prio;
    logic           pick_d;
    logic           pick_f;
    logic [31:0]    walign;

`ifdef EJ32_MB8_ARB_RR_EN
    // 1 = data was granted last; resets to fetch-last so data wins the first tie
    logic           dlast_q, dlast_d;
    assign data_prio = ~dlast_q;
`else
    assign data_prio = 1'b1;
`endif

    assign pick_d = d_req & (~f_req | data_prio);
    assign pick_f = f_req & ~pick_d;

    // Left-align store data so the first byte to write is always bits [31:24]
    always_comb begin
        case (d_len)
            2'b00:   walign = {d_vi[7:0], 24'h0};
            2'b01:   walign = {d_vi[15:0], 16'h0};
            default: walign = d_vi;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        isd_d    = isd_q;
        last_d   = last_q;
        k_d      = k_q;
        acc_d    = acc_q;
        wdat_d   = wdat_q;
        f_vo_d   = f_vo_q;
        d_vo_d   = d_vo_q;
        f_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        mem_we_d = 1'b0;
        mem_ai_d = mem_ai_q;
        mem_vi_d = mem_vi_q;
`ifdef EJ32_MB8_ARB_RR_EN
        dlast_d  = dlast_q;
`endif
        case (state_q)
            S_IDLE: begin
                k_d   = 2'd0;
                acc_d = 32'h0;
                if (pick_d) begin
                    isd_d    = 1'b1;
                    last_d   = (d_len == 2'b00) ? 2'd0 : ((d_len == 2'b01) ? 2'd1 : 2'd3);
                    mem_ai_d = d_ai;
`ifdef EJ32_MB8_ARB_RR_EN
                    dlast_d  = 1'b1;
`endif
                    if (d_we) begin
                        mem_we_d = 1'b1;
                        mem_vi_d = walign[31:24];
                        wdat_d   = walign << 8;
                        state_d  = S_WR;
                    end else begin
                        state_d  = S_RD;
                    end
                end else if (pick_f) begin
                    isd_d    = 1'b0;
                    last_d   = 2'd0;
                    mem_ai_d = f_ai;
`ifdef EJ32_MB8_ARB_RR_EN
                    dlast_d  = 1'b0;
`endif
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                // mem_vo now carries the byte addressed in the previous cycle
                if (k_q != 2'd0) begin
                    acc_d = {acc_q[23:0], mem_vo};
                end
                if (k_q == last_q) begin
                    state_d = S_RDL;
                end else begin
                    k_d      = k_q + 2'd1;
                    mem_ai_d = mem_ai_q + ASZ'(1);
                end
            end
            S_RDL: begin
                if (isd_q) begin
                    d_vo_d  = {acc_q[23:0], mem_vo};
                    d_ack_d = 1'b1;
                end else begin
                    f_vo_d  = mem_vo;
                    f_ack_d = 1'b1;
                end
                state_d = S_ACK;
            end
            S_WR: begin
                if (k_q == last_q) begin
                    d_ack_d = 1'b1;
                    state_d = S_ACK;
                end else begin
                    mem_we_d = 1'b1;
                    k_d      = k_q + 2'd1;
                    mem_ai_d = mem_ai_q + ASZ'(1);
                    mem_vi_d = wdat_q[31:24];
                    wdat_d   = wdat_q << 8;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            isd_q    <= 1'b0;
            last_q   <= 2'd0;
            k_q      <= 2'd0;
            acc_q    <= 32'h0;
            wdat_q   <= 32'h0;
            f_vo_q   <= 8'h0;
            d_vo_q   <= 32'h0;
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            mem_we_q <= 1'b0;
            mem_ai_q <= '0;
            mem_vi_q <= 8'h0;
            busy_q   <= 1'b0;
`ifdef EJ32_MB8_ARB_RR_EN
            dlast_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            isd_q    <= isd_d;
            last_q   <= last_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            wdat_q   <= wdat_d;
            f_vo_q   <= f_vo_d;
            d_vo_q   <= d_vo_d;
            f_ack_q  <= f_ack_d;
            d_ack_q  <= d_ack_d;
            mem_we_q <= mem_we_d;
            mem_ai_q <= mem_ai_d;
            mem_vi_q <= mem_vi_d;
            busy_q   <= busy_d;
`ifdef EJ32_MB8_ARB_RR_EN
            dlast_q  <= dlast_d;
`endif
        end
    end

    assign f_ack  = f_ack_q;
    assign f_vo   = f_vo_q;
    assign d_ack  = d_ack_q;
    assign d_vo   = d_vo_q;
    assign mem_we = mem_we_q;
    assign mem_ai = mem_ai_q;
    assign mem_vi = mem_vi_q;
    assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ej32_mb8_arb.sv
// ============================================================================
// tb_ej32_mb8_arb : directed self-checking bench for ej32_mb8_arb
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ej32_mb8_arb;

    localparam int ASZ = 17;

    logic           clk;
    logic           rst;
    logic           f_req;
    logic [ASZ-1:0] f_ai;
    logic           f_ack;
    logic [7:0]     f_vo;
    logic           d_req;
    logic           d_we;
    logic [1:0]     d_len;
    logic [ASZ-1:0] d_ai;
    logic [31:0]    d_vi;
    logic           d_ack;
    logic [31:0]    d_vo;
    logic           mem_we;
    logic [ASZ-1:0] mem_ai;
    logic [7:0]     mem_vi;
    logic [7:0]     mem_vo;
    logic           busy;

    int n_cmp;
    int n_err;
    int wcnt;

    logic [7:0] mem [0:(1<<ASZ)-1];

    ej32_mb8_arb #(.ASZ(ASZ)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_ai(f_ai), .f_ack(f_ack), .f_vo(f_vo),
        .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_ai(d_ai), .d_vi(d_vi),
        .d_ack(d_ack), .d_vo(d_vo),
        .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_vo(mem_vo),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte memory: read data appears one cycle after the address
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_ai] <= mem_vi;
            wcnt <= wcnt + 1;
        end
        mem_vo <= mem[mem_ai];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({mem_we, f_ack, d_ack, busy} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl: got we/fack/dack/busy=%b want 0000", {mem_we, f_ack, d_ack, busy});
        end
        n_cmp++;
        if (mem_ai !== 17'h0 || mem_vi !== 8'h0) begin
            n_err++; $display("FAIL reset_mem: got ai=%h vi=%h want 0/0", mem_ai, mem_vi);
        end
        n_cmp++;
        if (f_vo !== 8'h0 || d_vo !== 32'h0) begin
            n_err++; $display("FAIL reset_vo: got f_vo=%h d_vo=%h want 0/0", f_vo, d_vo);
        end
    endtask

    task automatic test_fetch();
        f_req = 1'b1; f_ai = 17'h00010;
        step();
        n_cmp++;
        if (mem_ai !== 17'h00010 || mem_we !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL fetch_c1: got ai=%h we=%b busy=%b want 00010/0/1", mem_ai, mem_we, busy);
        end
        step();
        n_cmp++;
        if (f_ack !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL fetch_c2: got ack=%b busy=%b want 0/1", f_ack, busy);
        end
        step();
        n_cmp++;
        if (f_ack !== 1'b1 || f_vo !== 8'hCA || busy !== 1'b1 || d_ack !== 1'b0) begin
            n_err++; $display("FAIL fetch_c3: got ack=%b vo=%h busy=%b dack=%b want 1/ca/1/0", f_ack, f_vo, busy, d_ack);
        end
        f_req = 1'b0;
        step();
        n_cmp++;
        if (f_ack !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL fetch_c4: got ack=%b busy=%b want 0/0", f_ack, busy);
        end
    endtask

    task automatic test_load4();
        d_req = 1'b1; d_we = 1'b0; d_len = 2'b11; d_ai = 17'h00100;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_cmp++;
            if (mem_ai !== 17'h00100 + 17'(c - 1) || mem_we !== 1'b0) begin
                n_err++; $display("FAIL load4_addr c%0d: got ai=%h we=%b want %h/0", c, mem_ai, mem_we, 17'h00100 + 17'(c - 1));
            end
        end
        step();
        n_cmp++;
        if (d_ack !== 1'b0) begin
            n_err++; $display("FAIL load4_c5: got ack=%b want 0", d_ack);
        end
        step();
        n_cmp++;
        if (d_ack !== 1'b1 || d_vo !== 32'h12345678 || f_ack !== 1'b0) begin
            n_err++; $display("FAIL load4_c6: got ack=%b vo=%h want 1/12345678", d_ack, d_vo);
        end
        d_req = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || d_ack !== 1'b0) begin
            n_err++; $display("FAIL load4_end: got busy=%b ack=%b want 0/0", busy, d_ack);
        end
    endtask

    task automatic test_store_wrap();
        int w0;
        w0 = wcnt;
        d_req = 1'b1; d_we = 1'b1; d_len = 2'b01; d_ai = 17'h1FFFF; d_vi = 32'hFFFFABCD;
        step();
        n_cmp++;
        if (mem_we !== 1'b1 || mem_ai !== 17'h1FFFF || mem_vi !== 8'hAB) begin
            n_err++; $display("FAIL store_c1: got we=%b ai=%h vi=%h want 1/1ffff/ab", mem_we, mem_ai, mem_vi);
        end
        step();
        n_cmp++;
        if (mem_we !== 1'b1 || mem_ai !== 17'h00000 || mem_vi !== 8'hCD) begin
            n_err++; $display("FAIL store_c2: got we=%b ai=%h vi=%h want 1/00000/cd", mem_we, mem_ai, mem_vi);
        end
        step();
        n_cmp++;
        if (d_ack !== 1'b1 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL store_c3: got ack=%b we=%b want 1/0", d_ack, mem_we);
        end
        d_req = 1'b0; d_we = 1'b0;
        step(); step();
        n_cmp++;
        if (mem[17'h1FFFF] !== 8'hAB || mem[17'h0] !== 8'hCD || (wcnt - w0) !== 2) begin
            n_err++; $display("FAIL store_mem: got %h %h writes=%0d want ab cd 2", mem[17'h1FFFF], mem[17'h0], wcnt - w0);
        end
    endtask

    task automatic test_load1();
        d_req = 1'b1; d_we = 1'b0; d_len = 2'b00; d_ai = 17'h00300;
        step();
        n_cmp++;
        if (mem_ai !== 17'h00300) begin
            n_err++; $display("FAIL load1_addr: got %h want 00300", mem_ai);
        end
        step(); step();
        n_cmp++;
        if (d_ack !== 1'b1 || d_vo !== 32'h0000009E) begin
            n_err++; $display("FAIL load1_vo: got ack=%b vo=%h want 1/0000009e", d_ack, d_vo);
        end
        n_cmp++;
        if (f_vo !== 8'hCA) begin
            n_err++; $display("FAIL fvo_hold: got %h want ca", f_vo);
        end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        f_req = 1'b1; f_ai = 17'h00010;
        d_req = 1'b1; d_we = 1'b0; d_len = 2'b00; d_ai = 17'h00300;
        step();
        n_cmp++;
        if (mem_ai !== 17'h00300) begin
            n_err++; $display("FAIL prio_first: got ai=%h want 00300", mem_ai);
        end
        step(); step();
        n_cmp++;
        if (d_ack !== 1'b1 || f_ack !== 1'b0) begin
            n_err++; $display("FAIL prio_dack: got dack=%b fack=%b want 1/0", d_ack, f_ack);
        end
        d_req = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL prio_idle: got busy=%b want 0", busy);
        end
        step();
        n_cmp++;
        if (mem_ai !== 17'h00010 || busy !== 1'b1) begin
            n_err++; $display("FAIL prio_second: got ai=%h busy=%b want 00010/1", mem_ai, busy);
        end
        step(); step();
        n_cmp++;
        if (f_ack !== 1'b1 || f_vo !== 8'hCA || d_ack !== 1'b0) begin
            n_err++; $display("FAIL prio_fack: got fack=%b vo=%h dack=%b want 1/ca/0", f_ack, f_vo, d_ack);
        end
        f_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b1; d_len = 2'b11; d_ai = 17'h00200; d_vi = 32'h11223344;
        step();
        n_cmp++;
        if (mem_we !== 1'b1 || mem_ai !== 17'h00200 || mem_vi !== 8'h11) begin
            n_err++; $display("FAIL rmid_c1: got we=%b ai=%h vi=%h want 1/00200/11", mem_we, mem_ai, mem_vi);
        end
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (mem_we !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmid_c3: got we=%b ack=%b busy=%b want 0/0/0", mem_we, d_ack, busy);
        end
        rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        n_cmp++;
        if (d_ack !== 1'b0 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL rmid_c4: got ack=%b we=%b want 0/0", d_ack, mem_we);
        end
        n_cmp++;
        if (mem[17'h200] !== 8'h11 || mem[17'h201] !== 8'h22 || mem[17'h202] !== 8'h00 || mem[17'h203] !== 8'h00) begin
            n_err++; $display("FAIL rmid_mem: got %h %h %h %h want 11 22 00 00",
                              mem[17'h200], mem[17'h201], mem[17'h202], mem[17'h203]);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; wcnt = 0;
        rst = 1'b1; f_req = 1'b0; f_ai = '0; d_req = 1'b0; d_we = 1'b0;
        d_len = 2'b00; d_ai = '0; d_vi = 32'h0;
        mem[17'h00010] = 8'hCA;
        mem[17'h00100] = 8'h12; mem[17'h00101] = 8'h34;
        mem[17'h00102] = 8'h56; mem[17'h00103] = 8'h78;
        mem[17'h1FFFF] = 8'h55; mem[17'h00000] = 8'h55;
        mem[17'h00300] = 8'h9E;
        mem[17'h00200] = 8'h00; mem[17'h00201] = 8'h00;
        mem[17'h00202] = 8'h00; mem[17'h00203] = 8'h00;
        test_reset();
        test_fetch();
        test_load4();
        test_store_wrap();
        test_load1();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
